otp_pad_arbiter: RTL

OTP_PAD_ARBITER -- requirements
Module: otp_pad_arbiter

---
 rtl/otp_pkg.sv | 29 ++
 rtl/otp_free_slot_enc.sv | 37 +++
 rtl/otp_pad_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/otp_pkg.sv
// ---------------------------------------------------------------------------
// otp_pkg
// Shared definitions for the one-time-pad arbiter:
//   - default slot count and data width
//   - arbiter FSM state encoding
//   - grant identifier (which requester owns the current transaction)
//   - index-width helper, so a one-slot build still gets a 1-bit index
// ---------------------------------------------------------------------------
package otp_pkg;

    localparam int OTP_SLOTS  = 8;
    localparam int OTP_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } otp_state_t;

    typedef enum logic {
        GRANT_ENC = 1'b0,
        GRANT_DEC = 1'b1
    } grant_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/otp_free_slot_enc.sv
// ---------------------------------------------------------------------------
// otp_free_slot_enc
// Priority encoder over the pad-slot occupancy bitmap.
// Ports:
//   slot_valid  in  SLOTS   occupancy bitmap, bit i set = slot i holds a pad
//   free_idx    out IDX_W   lowest index whose occupancy bit is clear
//                           (0 when no slot is free; qualify with all_full)
//   all_full    out 1       every slot is occupied
// ---------------------------------------------------------------------------
module otp_free_slot_enc
    import otp_pkg::*;
#(
    parameter  int SLOTS = OTP_SLOTS,
    localparam int IDX_W = idx_width(SLOTS)
) (
    input  logic [SLOTS-1:0] slot_valid,
    output logic [IDX_W-1:0] free_idx,
    output logic             all_full
);

    logic found;

    // Scan upward; the first clear bit wins and later ones are ignored.
    always_comb begin
        free_idx = '0;
        found    = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!found && !slot_valid[i]) begin
                free_idx = IDX_W'(i);
                found    = 1'b1;
            end
        end
    end

    assign all_full = &slot_valid;

endmodule

// File: rtl/otp_pad_arbiter.sv
// ---------------------------------------------------------------------------
// otp_pad_arbiter
// Arbitrates an encrypt and a decrypt requester over a small store of
// one-time pads drawn from an external LFSR. Encrypt takes the current LFSR
// value, parks it in the lowest free slot and returns data^pad. Decrypt
// consumes a stored pad exactly once and returns data^pad, or flags an error
// if the slot is empty.
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   ena                   admits new requests (in-flight work always finishes)
//   clear                 invalidates every slot; honoured only while idle
//   enc_req/enc_data      encrypt request and plaintext
//   enc_ack               one-cycle acknowledge to the encrypt requester
//   dec_req/dec_data      decrypt request and ciphertext
//   dec_slot              slot holding the pad to decrypt with
//   dec_ack               one-cycle acknowledge to the decrypt requester
//   pad_in                current LFSR value
//   pad_advance           steps the LFSR (only while an encrypt executes)
//   res_valid/res_ready   result handshake
//   res_data/res_slot     result data and the slot involved
//   res_err               decrypt targeted an empty slot
//   slot_valid            slot occupancy bitmap
//   full                  every slot occupied; encrypt is held off
//   busy                  a transaction is in flight
// ---------------------------------------------------------------------------
module otp_pad_arbiter
    import otp_pkg::*;
#(
    parameter  int SLOTS  = OTP_SLOTS,
    parameter  int DATA_W = OTP_DATA_W,
    localparam int IDX_W  = idx_width(SLOTS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ena,
    input  logic              clear,
    input  logic              enc_req,
    input  logic [DATA_W-1:0] enc_data,
    output logic              enc_ack,
    input  logic              dec_req,
    input  logic [DATA_W-1:0] dec_data,
    input  logic [IDX_W-1:0]  dec_slot,
    output logic              dec_ack,
    input  logic [DATA_W-1:0] pad_in,
    output logic              pad_advance,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [IDX_W-1:0]  res_slot,
    output logic              res_err,
    output logic [SLOTS-1:0]  slot_valid,
    output logic              full,
    output logic              busy
);

    otp_state_t state;
    otp_state_t state_next;

    grant_t winner;
    grant_t last_grant;
    grant_t grant_pick;

    logic [DATA_W-1:0] op_data;
    logic [IDX_W-1:0]  op_slot;
    logic [DATA_W-1:0] mem [SLOTS];

    logic [IDX_W-1:0]  free_idx;
    logic              enc_eligible;
    logic              dec_eligible;
    logic              grant_any;

    otp_free_slot_enc #(
        .SLOTS (SLOTS)
    ) u_free_slot_enc (
        .slot_valid (slot_valid),
        .free_idx   (free_idx),
        .all_full   (full)
    );

    // Eligibility is only meaningful while idle; clear wins over any grant.
    assign enc_eligible = (state == ST_IDLE) && ena && enc_req && !full;
    assign dec_eligible = (state == ST_IDLE) && ena && dec_req;
    assign grant_any    = (enc_eligible || dec_eligible) && !clear;

    // Round-robin on contention: whoever was not granted last goes next.
    always_comb begin
        if (enc_eligible && dec_eligible) begin
            grant_pick = (last_grant == GRANT_DEC) ? GRANT_ENC : GRANT_DEC;
        end else if (enc_eligible) begin
            grant_pick = GRANT_ENC;
        end else begin
            grant_pick = GRANT_DEC;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and outputs
    always_comb begin
        state_next  = state;
        enc_ack     = 1'b0;
        dec_ack     = 1'b0;
        pad_advance = 1'b0;
        res_valid   = 1'b0;
        busy        = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (grant_any) begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (winner == GRANT_ENC) begin
                    enc_ack     = 1'b1;
                    pad_advance = 1'b1;
                end else begin
                    dec_ack     = 1'b1;
                end
                state_next = ST_RESP;
            end
            ST_RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Grant capture, pad store, occupancy bitmap and result registers.
    // Everything here is cleared by reset so an aborted transaction leaves
    // no pad behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            winner     <= GRANT_ENC;
            last_grant <= GRANT_DEC;
            op_data    <= '0;
            op_slot    <= '0;
            slot_valid <= '0;
            res_data   <= '0;
            res_slot   <= '0;
            res_err    <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clear) begin
                        slot_valid <= '0;
                    end else if (grant_any) begin
                        winner     <= grant_pick;
                        last_grant <= grant_pick;
                        if (grant_pick == GRANT_ENC) begin
                            op_data <= enc_data;
                            op_slot <= free_idx;
                        end else begin
                            op_data <= dec_data;
                            op_slot <= dec_slot;
                        end
                    end
                end
                ST_EXEC: begin
                    res_slot <= op_slot;
                    if (winner == GRANT_ENC) begin
                        mem[op_slot]        <= pad_in;
                        slot_valid[op_slot] <= 1'b1;
                        res_data            <= pad_in ^ op_data;
                        res_err             <= 1'b0;
                    end else if (slot_valid[op_slot]) begin
                        // Pad is consumed: the slot becomes free again.
                        slot_valid[op_slot] <= 1'b0;
                        res_data            <= mem[op_slot] ^ op_data;
                        res_err             <= 1'b0;
                    end else begin
                        res_data <= '0;
                        res_err  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
